// File: rtl/ccff_bitstream_loader.sv
// Serialises configuration words MSB-first into the head of a CCFF chain and gates its shift clock.
// Optional chain-length self check (flush + single-one probe) is built in with CCFF_LEN_CHECK_EN.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int SW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT, S_FIN, S_FLUSH, S_PROBE, S_PCHK
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q;
  logic [CW-1:0]     bit_cnt;
  logic [SW-1:0]     sub_cnt;

`ifdef CCFF_LEN_CHECK_EN
  localparam int PW = $clog2(2*CHAIN_LEN + 1);
  localparam logic [PW-1:0] P_MATCH = PW'(CHAIN_LEN);
  localparam logic [PW-1:0] P_LIMIT = PW'(2*CHAIN_LEN);
  logic [PW-1:0] pcnt;
  logic          err_q;
  assign err = err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign err = 1'b0;
`endif

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) begin
`ifdef CCFF_LEN_CHECK_EN
        state_d = S_FLUSH;
`else
        state_d = S_LOAD;
`endif
      end
      S_LOAD:  if (cfg_valid) state_d = S_SHIFT;
      // Chain-full wins over end-of-word so a partial final word is truncated.
      S_SHIFT: if (bit_cnt == BIT_LAST)      state_d = S_FIN;
               else if (sub_cnt == SUB_LAST) state_d = S_LOAD;
      S_FIN:   state_d = S_IDLE;
`ifdef CCFF_LEN_CHECK_EN
      S_FLUSH: if (bit_cnt == BIT_LAST) state_d = S_PROBE;
      S_PROBE: state_d = S_PCHK;
      // Probe alternates shift/observe so the tail is seen without an input-to-output path.
      S_PCHK:  if (ccff_tail)            state_d = (pcnt == P_MATCH) ? S_LOAD : S_FIN;
               else if (pcnt == P_LIMIT) state_d = S_FIN;
               else                      state_d = S_PROBE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      sreg_q  <= '0;
      bit_cnt <= '0;
      sub_cnt <= '0;
`ifdef CCFF_LEN_CHECK_EN
      pcnt    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          bit_cnt <= '0;
`ifdef CCFF_LEN_CHECK_EN
          err_q   <= 1'b0;
`endif
        end
        S_LOAD: if (cfg_valid) begin
          sreg_q  <= cfg_data;
          sub_cnt <= '0;
        end
        S_SHIFT: begin
          sreg_q  <= sreg_q << 1;
          bit_cnt <= bit_cnt + CW'(1);
          sub_cnt <= sub_cnt + SW'(1);
        end
`ifdef CCFF_LEN_CHECK_EN
        S_FLUSH: begin
          bit_cnt <= bit_cnt + CW'(1);
          if (bit_cnt == BIT_LAST) pcnt <= '0;
        end
        S_PROBE: pcnt <= pcnt + PW'(1);
        S_PCHK: begin
          if (ccff_tail) begin
            if (pcnt == P_MATCH) bit_cnt <= '0;
            else                 err_q   <= 1'b1;
          end else if (pcnt == P_LIMIT) begin
            err_q <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_ready   = (state_q == S_LOAD);
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_FIN);
    ccff_clk_en = (state_q == S_SHIFT);
    ccff_head   = (state_q == S_SHIFT) ? sreg_q[WORD_W-1] : 1'b0;
`ifdef CCFF_LEN_CHECK_EN
    if (state_q == S_FLUSH) ccff_clk_en = 1'b1;
    if (state_q == S_PROBE) begin
      ccff_clk_en = 1'b1;
      ccff_head   = (pcnt == '0);
    end
`endif
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Drives the configuration flip-flop chain from its head end. It serialises configuration words into the chain, one bit per enabled shift.
- Sits between the bitstream source and the `ccff_head` of the first tile in the chain.
- Emits a clock-enable for the chain's prog_clk gate, so the chain advances only when the loader shifts.
- Counts bits and signals completion once exactly CHAIN_LEN bits have been shifted.

Parameters:
- CHAIN_LEN, 64, total configuration bits in the chain (>= 2).
- WORD_W, 8, width of incoming configuration words (>= 1).

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- pReset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  begin a load; sampled in IDLE only.
- cfg_data  input  WORD_W  configuration word; MSB shifted first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  loader accepts a word this cycle.
- ccff_head  output  1  serial bit into the chain.
- ccff_clk_en  output  1  chain shift enable; chain captures ccff_head at the rising edge where this is 1.
- ccff_tail  input  1  serial output of the last chain element.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when the load completes.
- err  output  1  chain-length check failed; sticky until next start.

Behaviour:
- Reset (pReset=0, asynchronous):
  - state=IDLE; cfg_ready=0, ccff_head=0, ccff_clk_en=0, busy=0, done=0, err=0; bit/word counters=0.
  - Reset mid-load abandons the load; chain contents are undefined.
- All outputs are decoded directly from registers; there are no combinational input-to-output paths.
- Counters:
  - bit_cnt has width $clog2(CHAIN_LEN+1) and counts shifts in the current phase.
  - sub_cnt has width $clog2(WORD_W+1) and counts bits within the current word.
- States:
  - IDLE: busy=0. On start=1, go to LOAD (or to FLUSH when the feature is built in); clear err and bit_cnt; busy=1 from the next cycle.
  - LOAD: cfg_ready=1, ccff_clk_en=0.
    - On cfg_valid&cfg_ready, latch cfg_data into the shift register, set sub_cnt=0, go to SHIFT.
    - If cfg_valid=0, stay in LOAD indefinitely.
  - SHIFT: cfg_ready=0, ccff_clk_en=1, ccff_head = shift register MSB.
    - Each cycle: shift left by 1, bit_cnt++, sub_cnt++.
    - When bit_cnt reaches CHAIN_LEN, go to FIN; this takes precedence over the end-of-word check.
    - Otherwise, when sub_cnt reaches WORD_W, go to LOAD.
    - If CHAIN_LEN is not a multiple of WORD_W, the low-order bits of the final word are discarded (never shifted).
  - FIN: ccff_clk_en=0, done=1 for exactly one cycle, then IDLE with busy=0.
- Throughput: one idle (LOAD) cycle per word minimum; each word = 1 + WORD_W cycles when cfg_valid is held high.
- Boundary cases:
  - start while busy: ignored.
  - cfg_valid outside LOAD: ignored, no data consumed.
  - ccff_tail: ignored in LOAD/SHIFT.
  - ccff_head: held at 0 whenever ccff_clk_en=0.

Optional Feature:
- Macro: CCFF_LEN_CHECK_EN.
- Built in: start enters FLUSH, then PROBE, then LOAD.
  - FLUSH: shift CHAIN_LEN zeros (ccff_clk_en=1, ccff_head=0).
  - PROBE: shift a single 1, then zeros; count shifts, including the 1, until ccff_tail samples 1 on a shift edge.
  - If the count equals CHAIN_LEN, go to LOAD.
  - If it differs, or 2*CHAIN_LEN shifts elapse with no 1 seen, set err=1, pulse done, return to IDLE without loading.
- Not built in: FLUSH/PROBE do not exist, ccff_tail is unused, and err is tied to 0.

Test Plan:
- Basic load:
  - Setup: CHAIN_LEN=16, WORD_W=8, start, words 0xA5 then 0x3C with valid held.
  - Required: ccff_head over the 16 enabled cycles = 1010010100111100; one LOAD gap between words; done pulses one cycle after the 16th shift; busy falls with done.
- Back-pressure:
  - Stimulus: cfg_valid low for 5 cycles between words.
  - Required: loader waits in LOAD, cfg_ready=1, ccff_clk_en=0 throughout; the bit sequence is unchanged.
- Partial final word:
  - Setup: CHAIN_LEN=12, words 0xFF and 0x90.
  - Required: 12 shifts = 111111111001; the 4 LSBs of 0x90 are dropped; done after 12 shifts.
- Reset mid-shift:
  - Stimulus: pReset=0 after the 5th shift.
  - Required: immediately all outputs 0 and state IDLE; a new start reloads cleanly.
- start while busy:
  - Stimulus: start pulsed repeatedly during SHIFT.
  - Required: no restart; bit_cnt continues; exactly one done pulse.
- Length check (CCFF_LEN_CHECK_EN):
  - Setup: behavioural chain model of 16 bits, CHAIN_LEN=16.
  - Required: 16 flush + 16 probe shifts, err=0, then load proceeds.
  - With a 15-bit model: err=1, done pulses, no cfg_ready assertion.
